// File: rtl/stream_mux_pkg.sv
// Shared types for the stream arbiter/multiplexer: FSM states and arbitration modes.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping modulo N_STATES.
module rr_arbiter #(
    parameter  int N_STATES = 4,
    localparam int SEL_W    = $clog2(N_STATES)
) (
    input  logic [N_STATES-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [SEL_W-1:0]    grant_o,
    output logic                found_o
);

    logic [2*N_STATES-1:0] req2;
    logic [N_STATES-1:0]   rot;
    int                    off;

    // Doubling the request vector turns the wrap-around search into a plain shift.
    assign req2 = {req_i, req_i};
    assign rot  = N_STATES'(req2 >> (int'(ptr_i) + 1));

    always_comb begin
        off     = 0;
        found_o = 1'b0;
        for (int k = N_STATES - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off     = k;
                found_o = 1'b1;
            end
        end
    end

    assign grant_o = SEL_W'((int'(ptr_i) + 1 + off) % N_STATES);

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel registered stream mux with select / round-robin arbitration and packet-level grant locking.
module stream_arb_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int N_STATES = 4,
    localparam int SEL_W    = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    i_x [N_STATES],
    input  logic [N_STATES-1:0] i_valid,
    input  logic [N_STATES-1:0] i_last,
    output logic [N_STATES-1:0] o_ready,
    input  logic                i_mode,
    input  logic [SEL_W-1:0]    i_select,
    output logic [WIDTH-1:0]    o_x,
    output logic                o_valid,
    output logic                o_last,
    output logic [SEL_W-1:0]    o_grant,
    input  logic                i_ready
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] rr_q, rr_d;
    logic [WIDTH-1:0] x_q;
    logic             valid_q;
    logic             last_q;
    logic [SEL_W-1:0] grant_q;

    logic             adv;
    logic             cand_ok;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_found;
    logic             xfer;
    logic [WIDTH-1:0] sel_x;
    logic             sel_last;
    mode_t            mode;

    assign mode = mode_t'(i_mode);
    assign adv  = !valid_q || i_ready;

    rr_arbiter #(
        .N_STATES(N_STATES)
    ) u_arb (
        .req_i  (i_valid),
        .ptr_i  (rr_q),
        .grant_o(arb_grant),
        .found_o(arb_found)
    );

    // Once a packet is open, only its channel may be served regardless of mode/select.
    always_comb begin
        cand    = lock_ch_q;
        cand_ok = 1'b1;
        if (state_q == IDLE) begin
            if (mode == MODE_RR) begin
                cand    = arb_grant;
                cand_ok = arb_found;
            end else begin
                cand    = i_select;
                cand_ok = (int'(i_select) < N_STATES);
            end
        end
    end

    for (genvar gi = 0; gi < N_STATES; gi++) begin : g_ready
        assign o_ready[gi] = adv && cand_ok && (cand == SEL_W'(gi));
    end

    always_comb begin
        sel_x    = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_STATES; k++) begin
            if (o_ready[k]) begin
                sel_x    = i_x[k];
                sel_last = i_last[k];
            end
        end
    end

    assign xfer = |(o_ready & i_valid);

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_d      = rr_q;
        if (xfer) begin
            if (state_q == IDLE) begin
                rr_d = cand;
                if (!sel_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = cand;
                end
            end else if (sel_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_q      <= SEL_W'(N_STATES - 1);
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_q      <= rr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            grant_q <= '0;
        end else if (xfer) begin
            x_q     <= sel_x;
            valid_q <= 1'b1;
            last_q  <= sel_last;
            grant_q <= cand;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_x     = x_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_grant = grant_q;

endmodule
